// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-side blocks.
// The state encoding is used by the transmitter; the command codes and frame length are also used by the receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    TX,
    WAIT_IDLE,
    ERR
  } ps2_tx_state_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // Device clock falling edges in one host-to-device frame: 8 data, parity, stop, ACK.
  localparam int FRAME_EDGES = 11;

  localparam int WDOG_W = 20;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Multi-flop synchronizer for one asynchronous PS/2 line, with a falling-edge strobe.
// Used for both PS2_CLK and PS2_DAT; the receiver can reuse it unchanged.
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic level,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Flops reset to the idle-bus level so releasing reset never looks like a falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q[0] <= line_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign fall  = prev_q & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send and shifts
// one command byte out on device clock falls, then checks the device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5500,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send_cmd,
  input  logic [7:0] cmd_byte,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       cmd_done,
  output logic       cmd_err
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [INH_W-1:0]  INH_LAST      = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0]  INH_START_BIT = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [WDOG_W-1:0] WDOG_LAST     = WDOG_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX      = '1;

  logic clk_s, clk_fall, dat_s, dat_fall_unused;

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk     (clk),
    .reset   (reset),
    .line_in (ps2_clk_in),
    .level   (clk_s),
    .fall    (clk_fall)
  );

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dat_sync (
    .clk     (clk),
    .reset   (reset),
    .line_in (ps2_dat_in),
    .level   (dat_s),
    .fall    (dat_fall_unused)
  );

  ps2_tx_state_e     state_q, state_d;
  logic [INH_W-1:0]  inh_q, inh_d;
  logic [3:0]        bit_q, bit_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [7:0]        shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              clk_oe_q, clk_oe_d;
  logic              dat_oe_q, dat_oe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [3:0]        next_bit;
  logic [WDOG_W-1:0] wdog_inc;
  logic              wdog_expired;

  assign next_bit     = bit_q + 4'd1;
  assign wdog_inc     = (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + WDOG_W'(1);
  assign wdog_expired = (wdog_q >= WDOG_LAST);

  // All outputs are registered so the open-drain enables never glitch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      inh_q    <= '0;
      bit_q    <= '0;
      wdog_q   <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      inh_q    <= inh_d;
      bit_q    <= bit_d;
      wdog_q   <= wdog_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    inh_d    = inh_q;
    bit_d    = bit_q;
    wdog_d   = wdog_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (send_cmd) begin
          shift_d  = cmd_byte;
          parity_d = odd_parity(cmd_byte);
          busy_d   = 1'b1;
          inh_d    = '0;
          clk_oe_d = 1'b1;
          dat_oe_d = (INHIBIT_CYCLES == 1);
          state_d  = INHIBIT;
        end
      end

      // Start bit is pulled one cycle early so it overlaps the final inhibit cycle.
      INHIBIT: begin
        inh_d = inh_q + INH_W'(1);
        if (inh_q == INH_START_BIT) dat_oe_d = 1'b1;
        if (inh_q == INH_LAST) begin
          clk_oe_d = 1'b0;
          state_d  = RTS;
        end
      end

      RTS: begin
        bit_d   = '0;
        wdog_d  = '0;
        state_d = TX;
      end

      // A device clock fall always takes priority over a watchdog expiry.
      TX: begin
        if (clk_fall) begin
          wdog_d = '0;
          bit_d  = next_bit;
          if (next_bit <= 4'd8) begin
            dat_oe_d = ~shift_q[0];
            shift_d  = {1'b0, shift_q[7:1]};
          end else if (next_bit == 4'd9) begin
            dat_oe_d = ~parity_q;
          end else if (next_bit == 4'd10) begin
            dat_oe_d = 1'b0;
          end else if (next_bit == 4'(FRAME_EDGES)) begin
            state_d = dat_s ? ERR : WAIT_IDLE;
          end
        end else if (wdog_expired) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          state_d  = ERR;
        end else begin
          wdog_d = wdog_inc;
        end
      end

      WAIT_IDLE: begin
        if (clk_s && dat_s) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (clk_fall) begin
          wdog_d = '0;
        end else if (wdog_expired) begin
          state_d = ERR;
        end else begin
          wdog_d = wdog_inc;
        end
      end

      ERR: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        err_d    = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign busy       = busy_q;
  assign cmd_done   = done_q;
  assign cmd_err    = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a behavioural PS/2 device clocks the frame out,
// and every sampled bit is compared against a scoreboard filled when the command is issued.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 20;
  localparam int TMO  = 200;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send_cmd = 1'b0;
  logic [7:0] cmd_byte = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2_clk_oe, ps2_dat_oe, busy, cmd_done, cmd_err;
  logic       clk_line, dat_line;

  assign clk_line = ~(ps2_clk_oe | dev_clk_low);
  assign dat_line = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .SYNC_STAGES    (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .send_cmd   (send_cmd),
    .cmd_byte   (cmd_byte),
    .ps2_clk_in (clk_line),
    .ps2_dat_in (dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .busy       (busy),
    .cmd_done   (cmd_done),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q[$];

  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, inh_cnt = 0, ovl_cnt = 0;
  int busy_bad = 0, both_bad = 0, last_err_cyc = 0, last_dat_cyc = 0;
  int done0, err0, inh0, ovl0, fall_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: pulse counts and the last cycle each event was seen.
  always @(negedge clk) begin
    if (reset) begin
      if (cmd_done) done_cnt <= done_cnt + 1;
      if (cmd_err) begin
        err_cnt      <= err_cnt + 1;
        last_err_cyc <= cyc;
      end
      if (ps2_clk_oe) inh_cnt <= inh_cnt + 1;
      if (ps2_clk_oe && ps2_dat_oe) ovl_cnt <= ovl_cnt + 1;
      if (ps2_dat_oe) last_dat_cyc <= cyc;
      if (cmd_done && busy) busy_bad <= busy_bad + 1;
      if (cmd_done && cmd_err) both_bad <= both_bad + 1;
    end
  end

  task automatic check_output(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Queue the frame the device should see on the line, then pulse send_cmd.
  task automatic apply_stimulus(input logic [7:0] b);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    exp_q.push_back(bit'(($countones(b) % 2) == 0));
    exp_q.push_back(1'b1);
    done0 = done_cnt;
    err0  = err_cnt;
    inh0  = inh_cnt;
    ovl0  = ovl_cnt;
    @(negedge clk);
    cmd_byte = b;
    send_cmd = 1'b1;
    @(negedge clk);
    send_cmd = 1'b0;
  endtask

  task automatic sample_bit(input int idx);
    if (exp_q.size() == 0) begin
      check_output($sformatf("sb_underflow_bit%0d", idx), 1, 0);
    end else begin
      check_output($sformatf("bit%0d", idx), int'(dat_line), int'(exp_q.pop_front()));
    end
  endtask

  // Behavioural device: generates up to 11 clock pulses, samples on each rising edge.
  task automatic device_frame(input int stop_edge, input bit give_ack,
                              input int inject_edge, input int reset_edge);
    int waited = 0;
    while (!(busy && !ps2_clk_oe && ps2_dat_oe) && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check_output("rts_seen", int'(waited < 400), 1);
    if (waited >= 400) return;
    repeat (HALF) @(negedge clk);
    sample_bit(0);
    for (int e = 1; e <= FRAME_EDGES; e++) begin
      if (e == FRAME_EDGES && give_ack) begin
        dev_dat_low = 1'b1;
        repeat (10) @(negedge clk);
      end
      if (e == inject_edge) begin
        cmd_byte = CMD_RESET;
        send_cmd = 1'b1;
        @(negedge clk);
        send_cmd = 1'b0;
      end
      dev_clk_low = 1'b1;
      fall_cyc = cyc;
      if (e == reset_edge) begin
        repeat (5) @(negedge clk);
        check_output("pre_reset_busy", int'(busy), 1);
        check_output("pre_reset_dat_oe", int'(ps2_dat_oe), 1);
        #2 reset = 1'b0;
        #1;
        check_output("async_reset_clk_oe", int'(ps2_clk_oe), 0);
        check_output("async_reset_dat_oe", int'(ps2_dat_oe), 0);
        check_output("async_reset_busy", int'(busy), 0);
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        return;
      end
      repeat (HALF) @(negedge clk);
      if (e < FRAME_EDGES) sample_bit(e);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
      if (e == FRAME_EDGES) dev_dat_low = 1'b0;
      if (e == stop_edge) return;
    end
  endtask

  task automatic wait_outcome();
    int w = 0;
    while (done_cnt == done0 && err_cnt == err0 && w < 600) begin
      @(negedge clk);
      w++;
    end
    check_output("outcome_seen", int'(w < 600), 1);
    repeat (5) @(negedge clk);
  endtask

  task automatic check_result(input string name, input int exp_done, input int exp_err);
    check_output({name, "_done_pulses"}, done_cnt - done0, exp_done);
    check_output({name, "_err_pulses"}, err_cnt - err0, exp_err);
    check_output({name, "_sb_leftover"}, exp_q.size(), 0);
    check_output({name, "_busy_after"}, int'(busy), 0);
    check_output({name, "_clk_oe_after"}, int'(ps2_clk_oe), 0);
    check_output({name, "_dat_oe_after"}, int'(ps2_dat_oe), 0);
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_clk_oe", int'(ps2_clk_oe), 0);
    check_output("rst_dat_oe", int'(ps2_dat_oe), 0);
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_cmd_done", int'(cmd_done), 0);
    check_output("rst_cmd_err", int'(cmd_err), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] set-LEDs command with ACK");
    apply_stimulus(CMD_SET_LEDS);
    device_frame(0, 1'b1, 0, 0);
    wait_outcome();
    check_output("t1_inhibit_cycles", inh_cnt - inh0, INH);
    check_output("t1_start_overlap", ovl_cnt - ovl0, 1);
    check_result("t1", 1, 0);

    $display("[TB] parity corner bytes");
    apply_stimulus(8'h00);
    device_frame(0, 1'b1, 0, 0);
    wait_outcome();
    check_result("t2a", 1, 0);
    apply_stimulus(8'h01);
    device_frame(0, 1'b1, 0, 0);
    wait_outcome();
    check_result("t2b", 1, 0);

    $display("[TB] device withholds ACK");
    apply_stimulus(8'hA5);
    device_frame(0, 1'b0, 0, 0);
    wait_outcome();
    check_result("t3", 0, 1);

    // Pin fall to internal fall takes 3 edges, expiry TMO edges later, cmd_err one edge after ERR.
    $display("[TB] device stops clocking after edge 4");
    apply_stimulus(CMD_ENABLE);
    device_frame(4, 1'b1, 0, 0);
    exp_q.delete();
    wait_outcome();
    check_output("t4_err_latency", last_err_cyc - fall_cyc, TMO + 4);
    check_output("t4_release_latency", last_dat_cyc - fall_cyc, TMO + 2);
    check_result("t4", 0, 1);

    $display("[TB] second send_cmd during transfer");
    apply_stimulus(CMD_ECHO);
    device_frame(0, 1'b1, 3, 0);
    wait_outcome();
    check_result("t5", 1, 0);

    $display("[TB] reset in the middle of a frame");
    apply_stimulus(8'h0F);
    device_frame(0, 1'b1, 0, 6);
    exp_q.delete();
    repeat (3) @(negedge clk);
    check_output("t6_held_clk_oe", int'(ps2_clk_oe), 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    apply_stimulus(CMD_ENABLE);
    device_frame(0, 1'b1, 0, 0);
    wait_outcome();
    check_result("t6", 1, 0);

    check_output("done_with_busy", busy_bad, 0);
    check_output("done_and_err_together", both_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
